io_stall_req: RTL and testbench
===============================

IO_STALL_REQ -- requirements
Module: io_stall_req

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 16: width of the switch input bus.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles needed to accept an enter level.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port io_read_req, input, 1: level, held high while an input instruction occupies MEM.
REQ-006 SHALL have port enter, input, 1: raw asynchronous confirm button.
REQ-007 SHALL have port switch, input, SW_WIDTH: raw switch bank, quasi-static.
REQ-008 SHALL have port stall_req_io, output, 1: stall request to the pipeline stall controller.
REQ-009 SHALL have port io_rdata, output, 32: captured switch value, zero-extended.
REQ-010 SHALL have port io_valid, output, 1: one-cycle pulse marking io_rdata newly captured.

Function
REQ-011 SHALL pass enter through a 2-flop synchronizer; all FSM decisions use only the synchronized level.
REQ-012 SHALL implement FSM states IDLE, WAIT_RELEASE, WAIT_PRESS, DONE.
REQ-013 IDLE: on io_read_req=1, go to WAIT_RELEASE; otherwise stay.
REQ-014 WAIT_RELEASE: on filtered enter=0, go to WAIT_PRESS, so a button still held from an earlier read is never reused.
REQ-015 WAIT_PRESS: on filtered enter=1, capture switch into io_rdata and go to DONE.
REQ-016 DONE: SHALL last exactly one cycle, then go to IDLE; io_read_req is ignored in DONE.
REQ-017 stall_req_io SHALL be combinational: 1 in WAIT_RELEASE and WAIT_PRESS, and 1 in IDLE when io_read_req=1; 0 otherwise.
REQ-018 stall_req_io SHALL therefore be high in the same cycle io_read_req first rises.
REQ-019 io_valid SHALL be 1 only in DONE; io_rdata SHALL hold its last captured value until the next capture.
REQ-020 io_rdata[31:SW_WIDTH] SHALL be 0; io_rdata[SW_WIDTH-1:0] SHALL be the raw switch value in the capture cycle.
REQ-021 Back-to-back reads: a new io_read_req in the cycle after DONE SHALL start a fresh transaction from IDLE, including the release requirement.
REQ-022 io_read_req dropping while in WAIT_RELEASE or WAIT_PRESS (pipeline flush) SHALL return the FSM to IDLE next cycle without capture and without io_valid.
REQ-023 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-024 While rst=1 at a clock edge: FSM to IDLE, synchronizer flops to 0, debounce counter to 0, filtered enter to 0, io_rdata to 0.
REQ-025 During reset cycles: io_valid=0; stall_req_io follows REQ-017 from IDLE.
REQ-026 Reset mid-transaction SHALL abort it with no capture and no io_valid pulse.

Configuration
REQ-027 Macro IO_DEBOUNCE_EN defined: filtered enter SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any disagreeing sample restarts the count.
REQ-028 Macro IO_DEBOUNCE_EN undefined: filtered enter SHALL equal the synchronized level; the counter and DEBOUNCE_CYCLES logic SHALL be absent; all other behaviour is unchanged.

Verification (IO_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4, SW_WIDTH=16)
REQ-029 Basic read: switch=16'hA5A5, io_read_req=1, enter low 10 cycles then high 10 cycles -> stall_req_io high from the first cycle until DONE; io_valid pulses once; io_rdata=32'h0000A5A5.
REQ-030 Held button: enter already high when io_read_req rises -> no capture until enter is low at least 4 cycles and then high at least 4 cycles.
REQ-031 Glitch: enter high for 2 cycles then low, during WAIT_PRESS -> no capture; stall_req_io stays 1.
REQ-032 Flush: io_read_req drops in WAIT_PRESS -> IDLE next cycle; stall_req_io=0; io_valid never pulses; io_rdata unchanged.
REQ-033 Reset mid-wait: rst=1 for 1 cycle in WAIT_PRESS -> IDLE; io_rdata=0; io_valid=0.
REQ-034 Back-to-back: two reads with switch 16'h0001 then 16'h0002, press/release each -> two single io_valid pulses carrying 1 then 2; with IO_DEBOUNCE_EN undefined, the same sequence completes with no debounce delay.

Source files
------------

// File: rtl/io_stall_req.sv
// -----------------------------------------------------------------------------
// io_stall_req
//
// Purpose:
//   Services a blocking "read switches" instruction. While the instruction sits
//   in MEM (io_read_req high), the pipeline is stalled until the operator
//   releases and then presses the confirm button. At that press the switch bank
//   is captured into io_rdata and io_valid pulses for one cycle.
//
//   A button still held down from an earlier read is never reused. The operator
//   must release the button and then press it again.
//
// Optional feature:
//   IO_DEBOUNCE_EN - when defined, the synchronized button level is debounced.
//                    The filtered level follows it only after DEBOUNCE_CYCLES
//                    consecutive disagreeing samples. When undefined, the
//                    filtered level is the synchronized level itself.
//
// Parameters:
//   SW_WIDTH        - width of the switch bank (1..32)
//   DEBOUNCE_CYCLES - stable cycles required before the filtered level flips
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-high reset
//   io_read_req  in   level, high while an input instruction occupies MEM
//   enter        in   raw asynchronous confirm button
//   switch       in   raw switch bank, quasi-static
//   stall_req_io out  combinational stall request to the stall controller
//   io_rdata     out  captured switch value, zero-extended to 32 bits
//   io_valid     out  one-cycle pulse marking io_rdata as newly captured
// -----------------------------------------------------------------------------
module io_stall_req #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                io_read_req,
    input  logic                enter,
    input  logic [SW_WIDTH-1:0] switch,
    output logic                stall_req_io,
    output logic [31:0]         io_rdata,
    output logic                io_valid
);

    if (SW_WIDTH < 1 || SW_WIDTH > 32) begin : g_bad_sw_width
        $error("io_stall_req: SW_WIDTH must be within 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("io_stall_req: DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        WAIT_PRESS   = 2'd2,
        DONE         = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic enter_s1;
    logic enter_s2;
    logic enter_f;
    logic capture;

    // Stage: two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            enter_s1 <= 1'b0;
            enter_s2 <= 1'b0;
        end else begin
            enter_s1 <= enter;
            enter_s2 <= enter_s1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt;
    logic             enter_db;

    // Stage: debounce filter. The counter holds the number of consecutive
    // samples that disagree with the filtered level. The filtered level flips
    // on the DEBOUNCE_CYCLES-th such sample, and any agreeing sample clears
    // the count. The counter saturates and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            enter_db <= 1'b0;
        end else if (enter_s2 == enter_db) begin
            db_cnt <= '0;
        end else if (db_cnt >= CNT_LAST) begin
            enter_db <= enter_s2;
            db_cnt   <= '0;
        end else if (db_cnt != '1) begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    assign enter_f = enter_db;
`else
    assign enter_f = enter_s2;
`endif

    // A drop of io_read_req (pipeline flush) takes priority over a press, so a
    // flushed instruction never captures.
    assign capture = (state == WAIT_PRESS) && io_read_req && enter_f;

    // Stage: FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (io_read_req) begin
                    state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!io_read_req) begin
                    state_nxt = IDLE;
                end else if (!enter_f) begin
                    state_nxt = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!io_read_req) begin
                    state_nxt = IDLE;
                end else if (enter_f) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The stall request is combinational, so it is already high in the first
    // cycle that io_read_req rises. While in reset, the FSM is treated as IDLE.
    always_comb begin
        stall_req_io = 1'b0;
        io_valid     = 1'b0;
        if (rst) begin
            stall_req_io = io_read_req;
        end else begin
            unique case (state)
                IDLE:         stall_req_io = io_read_req;
                WAIT_RELEASE: stall_req_io = 1'b1;
                WAIT_PRESS:   stall_req_io = 1'b1;
                DONE:         io_valid     = 1'b1;
            endcase
        end
    end

    // Stage: capture register. It holds its value until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= '0;
        end else if (capture) begin
            io_rdata <= 32'(switch);
        end
    end

endmodule

// File: tb/tb_io_stall_req.sv
module tb_io_stall_req;

    localparam int SW_W = 16;
    localparam int DEB  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            io_read_req = 1'b0;
    logic            enter = 1'b0;
    logic [SW_W-1:0] switch = '0;
    logic            stall_req_io;
    logic [31:0]     io_rdata;
    logic            io_valid;

    io_stall_req #(
        .SW_WIDTH        (SW_W),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io_read_req  (io_read_req),
        .enter        (enter),
        .switch       (switch),
        .stall_req_io (stall_req_io),
        .io_rdata     (io_rdata),
        .io_valid     (io_valid)
    );

    always #5 clk = ~clk;

    // Reference model: button delay line, optional filter, transaction status.
    bit          m_s1 = 0, m_s2 = 0;
`ifdef IO_DEBOUNCE_EN
    bit          m_filt = 0;
    int          m_run  = 0;
`endif
    bit          m_active = 0, m_released = 0, m_done = 0;
    logic [31:0] m_rdata = '0;
    logic [31:0] exp_q[$];
    int          n_capt  = 0;
    int          n_valid = 0;

    int checks = 0;
    int errors = 0;
    bit auto_drop = 1;

    function automatic bit filt_now();
`ifdef IO_DEBOUNCE_EN
        return m_filt;
`else
        return m_s2;
`endif
    endfunction

    task automatic model_update();
        bit f;
        f = filt_now();
        if (rst) begin
            m_s1 = 0; m_s2 = 0;
`ifdef IO_DEBOUNCE_EN
            m_filt = 0; m_run = 0;
`endif
            m_active = 0; m_released = 0; m_done = 0; m_rdata = '0;
            return;
        end
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (io_read_req) begin
                m_active = 1;
                m_released = 0;
            end
        end else if (!io_read_req) begin
            m_active = 0;
        end else if (!m_released) begin
            if (!f) m_released = 1;
        end else if (f) begin
            m_rdata = {16'h0000, switch};
            exp_q.push_back(m_rdata);
            n_capt++;
            m_active = 0;
            m_done = 1;
        end
`ifdef IO_DEBOUNCE_EN
        if (m_s2 != m_filt) begin
            m_run++;
            if (m_run == DEB) begin
                m_filt = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
`endif
        m_s2 = m_s1;
        m_s1 = enter;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_update();
        end
    end

    // Monitor: compares DUT outputs against the model on the falling edge.
    initial begin
        bit          exp_stall;
        bit          exp_valid;
        logic [31:0] v;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_stall = rst ? io_read_req : (m_done ? 1'b0 : (m_active | io_read_req));
            exp_valid = m_done && !rst;
            checks++;
            if (stall_req_io !== exp_stall) begin
                errors++;
                $display("FAIL stall t=%0t got %b exp %b", $time, stall_req_io, exp_stall);
            end
            checks++;
            if (io_valid !== exp_valid) begin
                errors++;
                $display("FAIL valid t=%0t got %b exp %b", $time, io_valid, exp_valid);
            end
            if (io_valid === 1'b1) begin
                n_valid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdata_pop t=%0t got %h exp <no capture>", $time, io_rdata);
                end else begin
                    v = exp_q.pop_front();
                    if (io_rdata !== v) begin
                        errors++;
                        $display("FAIL rdata_pop t=%0t got %h exp %h", $time, io_rdata, v);
                    end
                end
            end else if (exp_valid && exp_q.size() > 0) begin
                v = exp_q.pop_front();
            end
            checks++;
            if (io_rdata !== m_rdata) begin
                errors++;
                $display("FAIL rdata_hold t=%0t got %h exp %h", $time, io_rdata, m_rdata);
            end
        end
    end

    task automatic tick();
        bit was_done;
        was_done = m_done;
        @(posedge clk);
        #1;
        if (auto_drop && was_done) io_read_req = 1'b0;
    endtask

    task automatic hold(input int n, input bit e);
        enter = e;
        repeat (n) tick();
    endtask

    initial begin
        // Reset, including stall following io_read_req while in reset
        rst = 1'b1;
        hold(2, 0);
        io_read_req = 1'b1;
        tick();
        io_read_req = 1'b0;
        tick();
        rst = 1'b0;
        hold(2, 0);

        // Basic read
        switch = 16'hA5A5;
        io_read_req = 1'b1;
        hold(10, 0);
        hold(10, 1);
        hold(4, 0);

        // Button already held when the request rises
        hold(12, 1);
        switch = 16'h1234;
        io_read_req = 1'b1;
        hold(10, 1);
        hold(10, 0);
        hold(10, 1);
        hold(4, 0);

        // Short glitch during WAIT_PRESS, then flush
        switch = 16'hBEEF;
        io_read_req = 1'b1;
        hold(10, 0);
        hold(2, 1);
        hold(10, 0);
        io_read_req = 1'b0;
        hold(4, 0);

        // Reset while waiting for the press
        switch = 16'h7777;
        io_read_req = 1'b1;
        hold(10, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        io_read_req = 1'b0;
        hold(3, 0);

        // Back-to-back reads with the request held high throughout
        auto_drop = 0;
        switch = 16'h0001;
        io_read_req = 1'b1;
        hold(10, 0);
        hold(10, 1);
        switch = 16'h0002;
        hold(10, 0);
        hold(10, 1);
        io_read_req = 1'b0;
        auto_drop = 1;
        hold(4, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) io_read_req = ~io_read_req;
            if ($urandom_range(0, 4) == 0) enter = ~enter;
            switch = 16'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        io_read_req = 1'b0;
        hold(6, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty got %0d entries exp 0", exp_q.size());
        end
        checks++;
        if (n_valid != n_capt) begin
            errors++;
            $display("FAIL pulse_count got %0d exp %0d", n_valid, n_capt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
